// File: rtl/uart_serial_pkg.sv
// uart_serial_pkg: shared encodings, receive record layout and LCR helpers for uart_serial_core
package uart_serial_pkg;
  localparam int REC_W = 11;
  localparam int REC_FE = 0;
  localparam int REC_PE = 1;
  localparam int REC_BI = 2;
  localparam int REC_DLSB = 3;
  localparam int LCR_STB = 2;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;
  localparam int LCR_SP = 5;
  localparam int LCR_BC = 6;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP1, T_STOP2} tstate_t;
  typedef enum logic [3:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_PUSH, R_WAIT} rstate_t;
  function automatic logic [3:0] frame_bits(input logic [7:0] lcr);
    return 4'd7 + {2'b0, lcr[1:0]} + {3'b0, lcr[LCR_PEN]} + {3'b0, lcr[LCR_STB]};
  endfunction
  function automatic logic [7:0] data_mask(input logic [7:0] lcr);
    return 8'hff >> (2'd3 - lcr[1:0]);
  endfunction
  function automatic logic parity_bit(input logic [7:0] lcr, input logic [7:0] d);
    return (lcr[LCR_SP] && lcr[LCR_PEN]) ? ~lcr[LCR_EPS] : (lcr[LCR_EPS] ? ^d : ~^d);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with clear, level count and combinational head (0 when empty)
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CNT_W'(DEPTH) || do_pop);
  assign head = count == '0 ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_serial_core.sv
// uart_serial_core: 16550-style TX/RX serial engine with 16-entry FIFOs and character timeout.
// Define UART_LOOPBACK_EN to add the loopback input (TX stream fed to RX, stx_pad_o held high).
module uart_serial_core #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  wb_rst_ni,
  input  logic [7:0]            lcr,
  input  logic                  enable,
  input  logic                  tf_push,
  input  logic [7:0]            wb_dat_i,
  input  logic                  tx_reset,
  output logic                  stx_pad_o,
  output logic [2:0]            tstate,
  output logic [FIFO_CNT_W-1:0] tf_count,
  input  logic                  srx_pad_i,
  input  logic                  rf_pop,
  input  logic                  rx_reset,
  input  logic                  lsr_mask,
  output logic [10:0]           rf_data_out,
  output logic [FIFO_CNT_W-1:0] rf_count,
  output logic                  rf_push,
  output logic                  rf_overrun,
  output logic                  rf_error_bit,
  output logic [3:0]            rstate,
  output logic [9:0]            counter_t
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);
  import uart_serial_pkg::*;
  tstate_t ts, ts_n;
  rstate_t rs, rs_n;
  logic [3:0] tcnt, tcnt_n, rcnt, rcnt_n;
  logic [2:0] tbit, tbit_n, rbit, rbit_n, wl_m1;
  logic [7:0] tsh, tsh_n, tf_head, rdat, rdat_n;
  logic tpar, tpar_n, tf_pop, tx_line, rx_src, rx_s1, rx_in;
  logic rpar, rpar_n, rpe, rpe_n, rfe, rfe_n, rbi, rbi_n;
  logic rf_do_pop, rf_accept, lcr7_unused;
  logic [FIFO_CNT_W-1:0] err_cnt;
  logic [9:0] reload, tout_q;
  assign lcr7_unused = lcr[7];
  assign wl_m1 = {1'b1, lcr[1:0]};
  assign tstate = ts;
  assign rstate = rs;
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(FIFO_CNT_W)) u_tx_fifo (
    .clk(clk), .rst_n(wb_rst_ni), .push(tf_push), .pop(tf_pop), .clear(tx_reset),
    .din(wb_dat_i), .head(tf_head), .count(tf_count)
  );
  always_comb begin
    ts_n = ts;
    tcnt_n = tcnt;
    tbit_n = tbit;
    tsh_n = tsh;
    tpar_n = tpar;
    tf_pop = 1'b0;
    if (enable) begin
      tcnt_n = tcnt + 4'd1;
      case (ts)
        T_IDLE: begin
          tcnt_n = '0;
          tbit_n = '0;
          if (tf_count != '0) begin
            tf_pop = 1'b1;
            ts_n = T_START;
            tsh_n = tf_head;
            tpar_n = parity_bit(lcr, tf_head & data_mask(lcr));
          end
        end
        T_START: if (tcnt == 4'd15) ts_n = T_DATA;
        T_DATA: if (tcnt == 4'd15) begin
          tsh_n = tsh >> 1;
          tbit_n = tbit + 3'd1;
          ts_n = tbit == wl_m1 ? (lcr[LCR_PEN] ? T_PARITY : T_STOP1) : T_DATA;
        end
        T_PARITY: if (tcnt == 4'd15) ts_n = T_STOP1;
        T_STOP1: if (tcnt == 4'd15) ts_n = lcr[LCR_STB] ? T_STOP2 : T_IDLE;
        // 5-bit words use a stop length of 1.5 bits
        T_STOP2: if (tcnt == (lcr[1:0] == 2'd0 ? 4'd7 : 4'd15)) ts_n = T_IDLE;
        default: ts_n = T_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      ts <= T_IDLE;
      tcnt <= '0;
      tbit <= '0;
      tsh <= '0;
      tpar <= 1'b0;
    end else begin
      ts <= ts_n;
      tcnt <= tcnt_n;
      tbit <= tbit_n;
      tsh <= tsh_n;
      tpar <= tpar_n;
    end
  assign tx_line = ts == T_START ? 1'b0 : ts == T_DATA ? tsh[0] : ts == T_PARITY ? tpar : 1'b1;
`ifdef UART_LOOPBACK_EN
  assign stx_pad_o = loopback | (tx_line & ~lcr[LCR_BC]);
  assign rx_src = loopback ? tx_line : srx_pad_i;
`else
  assign stx_pad_o = tx_line & ~lcr[LCR_BC];
  assign rx_src = srx_pad_i;
`endif
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      rx_s1 <= 1'b1;
      rx_in <= 1'b1;
    end else begin
      rx_s1 <= rx_src;
      rx_in <= rx_s1;
    end
  // push and wait-idle are not tick-gated; bit sampling is
  always_comb begin
    rs_n = rs;
    rcnt_n = rcnt;
    rbit_n = rbit;
    rdat_n = rdat;
    rpar_n = rpar;
    rpe_n = rpe;
    rfe_n = rfe;
    rbi_n = rbi;
    if (rs == R_PUSH) rs_n = rbi ? R_WAIT : R_IDLE;
    else if (rs == R_WAIT) rs_n = rx_in ? R_IDLE : R_WAIT;
    else if (enable) begin
      rcnt_n = rcnt + 4'd1;
      case (rs)
        R_IDLE: begin
          rcnt_n = '0;
          rbit_n = '0;
          rdat_n = '0;
          rpar_n = 1'b0;
          if (!rx_in) rs_n = R_START;
        end
        R_START: if (rcnt == 4'd7) begin
          rcnt_n = '0;
          rs_n = rx_in ? R_IDLE : R_DATA;
        end
        R_DATA: if (rcnt == 4'd15) begin
          rdat_n[rbit] = rx_in;
          rbit_n = rbit + 3'd1;
          if (rbit == wl_m1) rs_n = lcr[LCR_PEN] ? R_PARITY : R_STOP;
        end
        R_PARITY: if (rcnt == 4'd15) begin
          rpar_n = rx_in;
          rs_n = R_STOP;
        end
        R_STOP: if (rcnt == 4'd15) begin
          rfe_n = ~rx_in;
          rpe_n = lcr[LCR_PEN] && (rpar != parity_bit(lcr, rdat));
          rbi_n = ~rx_in && rdat == '0 && ~rpar;
          rs_n = R_PUSH;
        end
        default: rs_n = R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      rs <= R_IDLE;
      rcnt <= '0;
      rbit <= '0;
      rdat <= '0;
      rpar <= 1'b0;
      rpe <= 1'b0;
      rfe <= 1'b0;
      rbi <= 1'b0;
    end else begin
      rs <= rs_n;
      rcnt <= rcnt_n;
      rbit <= rbit_n;
      rdat <= rdat_n;
      rpar <= rpar_n;
      rpe <= rpe_n;
      rfe <= rfe_n;
      rbi <= rbi_n;
    end
  assign rf_push = rs == R_PUSH;
  uart_sync_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH), .CNT_W(FIFO_CNT_W)) u_rx_fifo (
    .clk(clk), .rst_n(wb_rst_ni), .push(rf_push), .pop(rf_pop), .clear(rx_reset),
    .din({rdat, rbi, rpe, rfe}), .head(rf_data_out), .count(rf_count)
  );
  // error bit tracks how many stored records carry BI/PE/FE
  assign rf_do_pop = rf_pop && rf_count != '0;
  assign rf_accept = rf_push && (rf_count != FIFO_CNT_W'(FIFO_DEPTH) || rf_do_pop);
  assign rf_error_bit = err_cnt != '0;
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      err_cnt <= '0;
      rf_overrun <= 1'b0;
    end else begin
      err_cnt <= rx_reset ? '0 : err_cnt + FIFO_CNT_W'(rf_accept && (rbi || rpe || rfe))
                 - FIFO_CNT_W'(rf_do_pop && rf_data_out[REC_BI:REC_FE] != 3'b000);
      rf_overrun <= (rx_reset || lsr_mask) ? 1'b0 : rf_overrun | (rf_push && !rf_accept);
    end
  assign reload = {frame_bits(lcr), 6'd0} - 10'd1;
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni) tout_q <= '0;
    else if (rf_count == '0 || rf_push || rf_pop) tout_q <= reload;
    else if (enable && tout_q != '0) tout_q <= tout_q - 10'd1;
  assign counter_t = rf_count == '0 ? reload : tout_q;
endmodule

// File: tb/tb_uart_serial_core.sv
// tb_uart_serial_core: scoreboard bench with random TX/RX frames checked against a bit-level line model
module tb_uart_serial_core;
  logic clk = 0, wb_rst_ni = 0, enable = 1, tf_push = 0, tx_reset = 0, srx = 1;
  logic rx_reset = 0, lsr_mask = 0, mon_pop = 0, man_pop = 0;
  logic [7:0] lcr = 8'h03, wb_dat_i = 0;
  logic stx_pad_o, rf_push, rf_overrun, rf_error_bit;
  logic [2:0] tstate;
  logic [3:0] rstate;
  logic [4:0] tf_count, rf_count;
  logic [10:0] rf_data_out;
  logic [9:0] counter_t;
  int errors = 0, checks = 0, cyc = 0, push_seen = 0, push_cyc = 0;
  typedef struct packed {logic [7:0] l; logic [7:0] d;} txe_t;
  txe_t txq[$];
  logic [10:0] rxq[$];
  bit tx_lv[$];
  bit tx_mon = 1, drain = 0, exp_ovr = 0;

  always #5 clk = ~clk;

  uart_serial_core dut (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .lcr(lcr), .enable(enable), .tf_push(tf_push),
    .wb_dat_i(wb_dat_i), .tx_reset(tx_reset), .stx_pad_o(stx_pad_o), .tstate(tstate),
    .tf_count(tf_count), .srx_pad_i(srx), .rf_pop(mon_pop | man_pop), .rx_reset(rx_reset),
    .lsr_mask(lsr_mask), .rf_data_out(rf_data_out), .rf_count(rf_count), .rf_push(rf_push),
    .rf_overrun(rf_overrun), .rf_error_bit(rf_error_bit), .rstate(rstate), .counter_t(counter_t)
`ifdef UART_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int wlen(input logic [7:0] l);
    return 5 + int'(l[1:0]);
  endfunction

  function automatic bit par_of(input logic [7:0] l, input logic [7:0] d);
    bit x = 0;
    for (int i = 0; i < wlen(l); i++) x ^= d[i];
    if (l[5]) return !l[4];
    return l[4] ? x : !x;
  endfunction

  function automatic logic [10:0] rec_of(input logic [7:0] l, input logic [7:0] d, input bit pbit, input bit stop);
    logic [7:0] m = 0;
    bit pe, bi;
    for (int i = 0; i < wlen(l); i++) m[i] = d[i];
    pe = l[3] && (pbit != par_of(l, m));
    bi = (m == 0) && (!l[3] || !pbit) && !stop;
    return {m, bi, pe, !stop};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rf_push) begin
      push_seen <= push_seen + 1;
      push_cyc <= cyc;
    end

  // TX monitor: every tick of a frame must match the modelled line level
  initial forever begin
    @(negedge clk);
    if (tx_mon && wb_rst_ni && stx_pad_o == 0) begin
      if (txq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_frame: start bit seen with no byte queued");
        for (int n = 0; n < 400 && stx_pad_o == 0; n++) @(negedge clk);
      end else begin
        txe_t e;
        int bad;
        e = txq.pop_front();
        tx_lv.delete();
        bad = 0;
        for (int i = 0; i < 16; i++) tx_lv.push_back(0);
        for (int b = 0; b < wlen(e.l); b++) for (int i = 0; i < 16; i++) tx_lv.push_back(e.d[b]);
        if (e.l[3]) for (int i = 0; i < 16; i++) tx_lv.push_back(par_of(e.l, e.d));
        for (int i = 0; i < (!e.l[2] ? 16 : (e.l[1:0] == 0 ? 24 : 32)); i++) tx_lv.push_back(1);
        for (int i = 0; i < tx_lv.size(); i++) begin
          if (i != 0) @(negedge clk);
          if (stx_pad_o !== tx_lv[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL tx_frame: lcr=%0h data=%0h got %0d wrong ticks expected 0", e.l, e.d, bad);
        end
      end
    end
  end

  // RX monitor: whenever the FIFO holds a record and draining is on, compare and pop
  initial forever begin
    @(negedge clk);
    mon_pop = 0;
    if (drain && rf_count != 0) begin
      if (rxq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_record: got %0h expected no record", rf_data_out);
      end else chk("rx_record", rf_data_out, rxq.pop_front());
      mon_pop = 1;
    end
  end

  task automatic tx_push(input logic [7:0] d);
    tf_push = 1;
    wb_dat_i = d;
    txq.push_back({lcr, d});
    @(negedge clk);
    tf_push = 0;
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while ((txq.size() != 0 || tstate != 0 || tf_count != 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("tx_done_in_time", n < 6000, 1);
  endtask

  task automatic drive(input bit v, input int n);
    srx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] d, input bit flip, input bit stop);
    bit p;
    p = par_of(lcr, d) ^ flip;
    if (rxq.size() >= 16) exp_ovr = 1;
    else rxq.push_back(rec_of(lcr, d, p, stop));
    drive(0, 16);
    for (int b = 0; b < wlen(lcr); b++) drive(d[b], 16);
    if (lcr[3]) drive(p, 16);
    drive(stop, 16);
    if (lcr[2]) drive(1, 16);
    drive(1, 20);
  endtask

  task automatic wait_rx_drained();
    int n = 0;
    while ((rxq.size() != 0 || rf_count != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_drained", rf_count, 0);
  endtask

  task automatic pop_head();
    if (rxq.size() == 0) chk("rx_head_expected", rf_count, 0);
    else chk("rx_head", rf_data_out, rxq.pop_front());
    man_pop = 1;
    @(negedge clk);
    man_pop = 0;
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk("rst_stx", stx_pad_o, 1);
    chk("rst_tstate", tstate, 0);
    chk("rst_rstate", rstate, 0);
    chk("rst_tf_count", tf_count, 0);
    chk("rst_rf_count", rf_count, 0);
    chk("rst_rf_push", rf_push, 0);
    chk("rst_overrun", rf_overrun, 0);
    chk("rst_error_bit", rf_error_bit, 0);
    chk("rst_rf_data", rf_data_out, 0);
    chk("rst_counter_t", counter_t, 639);
    wb_rst_ni = 1;
    @(negedge clk);
    tx_push(8'h55);
    wait_tx_done();
    chk("tstate_back_idle", tstate, 0);
    for (int k = 0; k < 3; k++) begin
      lcr = 8'($urandom) & 8'hBF;
      for (int j = 0; j < 4; j++) tx_push(8'($urandom));
      wait_tx_done();
    end
    tx_mon = 0;
    lcr = 8'h43;
    @(negedge clk);
    chk("break_ctrl_low", stx_pad_o, 0);
    chk("break_ctrl_tstate", tstate, 0);
    lcr = 8'h03;
    @(negedge clk);
    chk("break_ctrl_release", stx_pad_o, 1);
    tx_mon = 1;
    lcr = 8'h1B;
    p0 = push_seen;
    send_rx(8'hA5, 0, 1);
    chk("rx_push_pulse", push_seen - p0, 1);
    chk("rx_count_one", rf_count, 1);
    chk("rx_record_a5", rf_data_out, 11'h528);
    chk("rx_no_error", rf_error_bit, 0);
    send_rx(8'hA5, 1, 1);
    send_rx(8'hA5, 0, 0);
    chk("rx_count_three", rf_count, 3);
    chk("rx_error_set", rf_error_bit, 1);
    pop_head();
    pop_head();
    chk("rx_fe_record", rf_data_out, 11'h529);
    chk("rx_error_still", rf_error_bit, 1);
    rx_reset = 1;
    @(negedge clk);
    rx_reset = 0;
    rxq.delete();
    chk("rx_reset_count", rf_count, 0);
    chk("rx_reset_error", rf_error_bit, 0);
    p0 = push_seen;
    rxq.push_back(11'h005);
    drive(0, 2 * 11 * 16);
    chk("break_one_push", push_seen - p0, 1);
    chk("break_rstate_wait", rstate, 6);
    chk("break_count", rf_count, 1);
    drive(1, 8);
    chk("break_rstate_idle", rstate, 0);
    drain = 1;
    wait_rx_drained();
    for (int k = 0; k < 3; k++) begin
      lcr = 8'($urandom) & 8'hBF;
      for (int j = 0; j < 5; j++) send_rx(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      wait_rx_drained();
    end
    drain = 0;
    lcr = 8'h03;
    exp_ovr = 0;
    for (int j = 0; j < 17; j++) send_rx(8'($urandom), 0, 1);
    chk("ovr_count_full", rf_count, 16);
    chk("ovr_set", rf_overrun, 1);
    chk("ovr_model", rf_overrun, exp_ovr);
    lsr_mask = 1;
    @(negedge clk);
    lsr_mask = 0;
    chk("ovr_cleared", rf_overrun, 0);
    drain = 1;
    wait_rx_drained();
    drain = 0;
    send_rx(8'($urandom), 0, 1);
    for (int n = 0; n < 2000 && cyc < push_cyc + 639; n++) @(negedge clk);
    chk("tout_one_left", counter_t, 1);
    @(negedge clk);
    chk("tout_zero", counter_t, 0);
    repeat (20) @(negedge clk);
    chk("tout_hold_zero", counter_t, 0);
    pop_head();
    chk("tout_reload_pop", counter_t, 639);
    chk("tout_empty", rf_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/uart_serial_core.md
Name: uart_serial_core

Overview:
- 16550-compatible serial engine: one transmitter and one receiver, each with a 16-entry FIFO.
- Sits under the UART register block, which supplies the line control register, the 16x baud `enable` tick, FIFO push/pop strobes and reset/mask strobes.
- Returns FIFO levels, the receive record, error flags, the character timeout counter and FSM states for LSR/IIR generation.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO.
- FIFO_CNT_W, 5, width of count outputs; must satisfy 2^FIFO_CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  clock.
- wb_rst_ni  in  1  async active-low reset.
- lcr  in  8  line control: [1:0] word length 5..8, [2] stop bits, [3] parity enable, [4] even parity, [5] stick parity, [6] break control, [7] ignored.
- enable  in  1  one-cycle 16x-baud tick.
- tf_push  in  1  write wb_dat_i into TX FIFO.
- wb_dat_i  in  8  TX data.
- tx_reset  in  1  clear TX FIFO.
- stx_pad_o  out  1  serial out, idle high.
- tstate  out  3  TX FSM state.
- tf_count  out  FIFO_CNT_W  TX FIFO level.
- srx_pad_i  in  1  serial in.
- rf_pop  in  1  discard RX FIFO head.
- rx_reset  in  1  clear RX FIFO.
- lsr_mask  in  1  LSR-read strobe.
- rf_data_out  out  11  RX head record: [10:3] data, [2] break, [1] parity error, [0] framing error.
- rf_count  out  FIFO_CNT_W  RX FIFO level.
- rf_push  out  1  one-cycle pulse when a record is written.
- rf_overrun  out  1  sticky overrun.
- rf_error_bit  out  1  any stored record has bits [2:0] nonzero.
- rstate  out  4  RX FSM state.
- counter_t  out  10  character-timeout counter.

Behaviour:
Reset values:
- stx_pad_o = 1; tstate = 0; rstate = 0.
- Both FIFOs empty, counts 0; rf_overrun = 0; rf_push = 0; rf_error_bit = 0.
- counter_t = reload value; RX synchronizer = 1.

Frame and bit timing:
- Frame bits = 1 start + (5+lcr[1:0]) data + lcr[3] parity + stop.
- One bit = 16 enable ticks.
- Stop = 16 ticks, or 32 when lcr[2]=1; 24 when lcr[2]=1 and word length is 5.

Parity:
- Normal: even = XOR(data), odd = ~XOR(data).
- Stick (lcr[5]&lcr[3]): parity bit = ~lcr[4].

Transmitter:
- tstate encoding: 0 idle, 1 start, 2 data (LSB first), 3 parity, 4 stop1, 5 stop2.
- In idle with tf_count>0 on an enable tick: pop the head and go to start.
- lcr[6]=1 forces stx_pad_o=0 without disturbing the FSM.
- tf_push when full is dropped.
- tx_reset empties the FIFO; a frame in progress completes.

Receiver:
- srx_pad_i passes through a 2-flop synchronizer.
- rstate encoding: 0 idle, 1 start check, 2 data, 3 parity, 4 stop, 5 push, 6 wait-idle.
- A low level in idle starts a 16-tick bit timer and moves to state 1.
- At tick 8, a still-low line proceeds; a high line returns to idle as a glitch.
- Each following bit is sampled mid-bit, 16 ticks apart.
- Unused upper data bits are stored as 0.
- Only the first stop bit is checked; a low stop sets framing error.
- Break: data, parity and stop all 0. Store record {0, BI=1, PE per parity check, FE=1}, then wait in state 6 for line high before accepting a new start.

RX FIFO rules:
- rf_push pulses the cycle the record is written.
- Push when full: record dropped, rf_overrun set.
- rf_overrun clears on lsr_mask or rx_reset.
- rf_pop when empty is ignored.
- Simultaneous push and pop: both happen, count unchanged.
- rx_reset empties the FIFO and clears rf_error_bit.
- rf_data_out is the combinational head; 0 when empty.

counter_t:
- Reload = frame bits × 64 − 1, using 1 stop bit when lcr[2]=0 and 2 stop bits when lcr[2]=1.
- Reload when rf_count==0, on rf_push, or on rf_pop.
- Otherwise decrement on enable ticks and hold at 0.

Optional Feature:
UART_LOOPBACK_EN:
- Defined: adds input loopback (1 bit). When loopback=1, the receiver input is the internal TX serial stream and stx_pad_o is held 1.
- Undefined: no port; the receiver always uses srx_pad_i.

Decomposition:
- Package uart_serial_pkg: record field indices (data [10:3], BI 2, PE 1, FE 0); tstate/rstate encodings; LCR bit indices; function returning frame-bit count from lcr.
- One sub-module, uart_sync_fifo (parameterized width/depth, push/pop/clear, count, head), instantiated for TX (8-bit) and RX (11-bit).

Test Plan:
- lcr=8'h03, enable every cycle, push 8'h55 -> stx_pad_o gives start 0 then bits 1,0,1,0,1,0,1,0 and stop 1, each held 16 ticks; tstate returns to 0.
- lcr=8'h1B, RX frame of 8'hA5 with correct even parity -> rf_push pulse, rf_count=1, rf_data_out={8'hA5,3'b000}, rf_error_bit=0.
- Same frame with wrong parity, then one with low stop -> records with [1]=1 and [0]=1 respectively; rf_error_bit=1; rx_reset -> rf_count=0, rf_error_bit=0.
- Line held low for 2 frame times -> one record {8'h00,BI=1,FE=1}; rstate=6 until line goes high.
- Send 17 frames without popping -> rf_count=16, rf_overrun=1; lsr_mask -> rf_overrun=0.
- One byte received, no pops, lcr=8'h03 -> counter_t reaches 0 after 639 ticks; rf_pop reloads it to 639.
